// File: rtl/xpar_mbox.sv
// xpar_mbox: parallel-bus responder mailbox with an RX FIFO (host -> CPU)
// and a TX FIFO (CPU -> host), plus sticky underrun/overflow flags.
module xpar_mbox #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PADDR_W = 12,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PADDR_W-1:0] par_addr,
  input  logic [DATA_W-1:0]  par_out,
  input  logic               par_we,
  input  logic               par_re,
  output logic [DATA_W-1:0]  par_in,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] rx_mem_q [DEPTH];
  logic [DATA_W-1:0] tx_mem_q [DEPTH];

  logic [PTR_W-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [PTR_W-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic             rx_unf_q, rx_unf_d, tx_ovf_q, tx_ovf_d;

  logic [1:0]        addr;
  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic              rx_push, rx_pop, tx_push, tx_pop;
  logic              unf_set, ovf_set, unf_clr, ovf_clr;
  logic [DATA_W-1:0] status;

  assign addr     = par_addr[1:0];
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);

  assign s_ready = !rx_full;
  assign m_valid = !tx_empty;
  assign m_data  = tx_mem_q[tx_rd_q];

  // Event decode; a write strobe masks any concurrent read strobe.
  always_comb begin
    rx_push = s_valid && s_ready;
    tx_pop  = m_valid && m_ready;
    rx_pop  = 1'b0;
    tx_push = 1'b0;
    unf_set = 1'b0;
    ovf_set = 1'b0;
    unf_clr = 1'b0;
    ovf_clr = 1'b0;
    if (par_we) begin
      if (addr == 2'd0) begin
        tx_push = !tx_full;
        ovf_set = tx_full;
      end else if (addr == 2'd1) begin
        unf_clr = par_out[4];
        ovf_clr = par_out[5];
      end
    end else if (par_re && addr == 2'd0) begin
      rx_pop  = !rx_empty;
      unf_set = rx_empty;
    end
  end

  // Next-state for pointers, counts and sticky flags (set beats clear).
  always_comb begin
    rx_wr_d  = rx_push ? rx_wr_q + PTR_W'(1) : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + PTR_W'(1) : rx_rd_q;
    tx_wr_d  = tx_push ? tx_wr_q + PTR_W'(1) : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + PTR_W'(1) : tx_rd_q;
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_W'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_W'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_W'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_W'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    rx_unf_d = (rx_unf_q && !unf_clr) || unf_set;
    tx_ovf_d = (tx_ovf_q && !ovf_clr) || ovf_set;
  end

  // Status word and zero-wait-state read mux.
  always_comb begin
    status              = '0;
    status[0]           = rx_empty;
    status[1]           = rx_full;
    status[2]           = tx_empty;
    status[3]           = tx_full;
    status[4]           = rx_unf_q;
    status[5]           = tx_ovf_q;
    status[8 +: CNT_W]  = rx_cnt_q;
    status[16 +: CNT_W] = tx_cnt_q;
    case (addr)
      2'd0:    par_in = rx_empty ? '0 : rx_mem_q[rx_rd_q];
      2'd1:    par_in = status;
      default: par_in = '0;
    endcase
  end

  // FIFO storage; not reset, only occupied entries are ever visible.
  always_ff @(posedge clk) begin
    if (!rst && rx_push) rx_mem_q[rx_wr_q] <= s_data;
    if (!rst && tx_push) tx_mem_q[tx_wr_q] <= par_out;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      rx_unf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      rx_unf_q <= rx_unf_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

endmodule
